// File: rtl/obi_sbr_mem_responder.sv
// obi_sbr_mem_responder: OBI subordinate backed by a word-addressed memory with fixed
// latency, bounded outstanding count and in-order, backpressurable responses.
module obi_sbr_mem_responder #(
    parameter int unsigned        ADDR_W          = 32,
    parameter int unsigned        DATA_W          = 32,
    parameter int unsigned        ID_W            = 1,
    parameter logic [ADDR_W-1:0]  BASE_ADDR       = 32'h2000_0000,
    parameter int unsigned        N_WORDS         = 1024,
    parameter int unsigned        LATENCY         = 2,
    parameter int unsigned        MAX_OUTSTANDING = 4,
    localparam int unsigned       STRB_W          = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [STRB_W-1:0] be_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ID_W-1:0]   aid_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ID_W-1:0]   rid_o,
    output logic              err_o,
    output logic              busy_o
);
    localparam int unsigned IW = N_WORDS > 1 ? $clog2(N_WORDS) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;

    typedef struct packed {
        logic              v;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] d;
        logic              e;
    } rsp_t;

    logic [DATA_W-1:0] mem [N_WORDS];
    rsp_t              pipe_q [LATENCY];
    rsp_t              fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     cnt_q, fcnt_q;
    logic [ADDR_W-3:0] woff;
    logic [IW-1:0]     idx;
    logic              in_rng, accept, retire, push, pop, fifo_empty;
    rsp_t              new_rsp, tail, head;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign woff   = (ADDR_W-2)'((addr_i - BASE_ADDR) >> 2);
    assign in_rng = (addr_i >= BASE_ADDR) && (woff < (ADDR_W-2)'(N_WORDS));
    assign idx    = woff[IW-1:0];
    assign gnt_o  = !rst_i && (cnt_q < CW'(MAX_OUTSTANDING));
    assign accept = req_i && gnt_o;

    // Idle pipeline slots carry all-zero payload so an empty head presents zeros.
    always_comb begin
        new_rsp    = '0;
        new_rsp.v  = accept;
        new_rsp.id = accept ? aid_i : '0;
        new_rsp.d  = (accept && in_rng && !we_i) ? mem[idx] : '0;
        new_rsp.e  = accept && !in_rng;
    end

    // An empty FIFO is bypassed so the last pipeline stage is seen the cycle it arrives.
    assign fifo_empty = (fcnt_q == '0);
    assign tail       = pipe_q[LATENCY-1];
    assign head       = fifo_empty ? tail : fifo_q[rd_ptr_q];
    assign rvalid_o   = head.v;
    assign rdata_o    = head.d;
    assign rid_o      = head.id;
    assign err_o      = head.e;
    assign busy_o     = (cnt_q != '0);
    assign retire     = rvalid_o && rready_i;
    assign pop        = retire && !fifo_empty;
    assign push       = tail.v && !(fifo_empty && rready_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            fcnt_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            cnt_q  <= cnt_q + CW'(accept) - CW'(retire);
            fcnt_q <= fcnt_q + CW'(push) - CW'(pop);
            if (push) wr_ptr_q <= nxt(wr_ptr_q);
            if (pop) rd_ptr_q <= nxt(rd_ptr_q);
            pipe_q[0] <= new_rsp;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= tail;
        if (accept && we_i && in_rng)
            for (int k = 0; k < STRB_W; k++)
                if (be_i[k]) mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
    end
endmodule

// File: tb/tb_obi_sbr_mem_responder.sv
// tb_obi_sbr_mem_responder: vector table plus hand sequences, responses checked via a scoreboard queue.
module tb_obi_sbr_mem_responder;
    localparam int LAT = 2;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        id;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] rd;
        logic        err;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk = 0, rst = 1, req = 0, we = 0, rready = 1, aid = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [3:0] be = 0;
    logic gnt, rvalid, err, busy, rid;
    logic [31:0] rdata;
    int n_vec = 0, n_bad = 0, cyc = 0, stalls = 0;
    exp_t sb[$];

    obi_sbr_mem_responder dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .aid_i(aid), .rvalid_o(rvalid), .rready_i(rready),
        .rdata_o(rdata), .rid_o(rid), .err_o(err), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rvalid && rready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rid=%0d rdata=%h err=%0d, expected none", rid, rdata, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rid", rid, e.id);
                chk("rdata", rdata, e.rd);
                chk("err", err, e.err);
                if (e.lat) chk("latency", cyc - e.acc, LAT);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input vec_t v, input bit lat);
        int w = 0;
        req = 1; we = v.we; addr = v.addr; be = v.be; wdata = v.wd; aid = v.id;
        @(negedge clk);
        while (!gnt && w < 20) begin
            w++;
            @(negedge clk);
        end
        stalls += w;
        if (gnt) sb.push_back('{v.id, v.rd, v.err, cyc, lat});
        else begin
            n_vec++;
            n_bad++;
            $display("FAIL grant_timeout: got gnt=0 for 20 cycles at addr %h, expected gnt=1", v.addr);
        end
        @(posedge clk);
        #1;
        req = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500us, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[16];
        vec_t v;
        vt[0]  = '{1'b1, 32'h2000_0010, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0};
        vt[1]  = '{1'b0, 32'h2000_0010, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0};
        vt[2]  = '{1'b1, 32'h2000_0010, 4'h5, 32'h1122_3344, 1'b1, 32'h0, 1'b0};
        vt[3]  = '{1'b0, 32'h2000_0010, 4'hF, 32'h0,         1'b0, 32'hDE22_BE44, 1'b0};
        vt[4]  = '{1'b1, 32'h2000_0000, 4'hF, 32'hA5A5_0001, 1'b0, 32'h0, 1'b0};
        vt[5]  = '{1'b0, 32'h1FFF_FFFC, 4'hF, 32'h0,         1'b1, 32'h0, 1'b1};
        vt[6]  = '{1'b1, 32'h2000_1000, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1};
        vt[7]  = '{1'b0, 32'h2000_0000, 4'hF, 32'h0,         1'b1, 32'hA5A5_0001, 1'b0};
        vt[8]  = '{1'b1, 32'h2000_0FFC, 4'hF, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0};
        vt[9]  = '{1'b0, 32'h2000_0FFC, 4'hF, 32'h0,         1'b1, 32'h0BAD_F00D, 1'b0};
        vt[10] = '{1'b1, 32'h2000_0020, 4'hF, 32'hCAFE_0020, 1'b0, 32'h0, 1'b0};
        vt[11] = '{1'b0, 32'h2000_0020, 4'hF, 32'h0,         1'b1, 32'hCAFE_0020, 1'b0};
        vt[12] = '{1'b1, 32'h2000_0024, 4'hF, 32'h1234_5678, 1'b0, 32'h0, 1'b0};
        vt[13] = '{1'b1, 32'h2000_0024, 4'h0, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0};
        vt[14] = '{1'b0, 32'h2000_0024, 4'hF, 32'h0,         1'b0, 32'h1234_5678, 1'b0};
        vt[15] = '{1'b0, 32'h2000_0013, 4'hF, 32'h0,         1'b1, 32'hDE22_BE44, 1'b0};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rid", rid, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 0;
        tick(2);

        // table: writes, partial write, out of range, boundaries, back-to-back
        for (int i = 0; i < 16; i++) issue(vt[i], 1'b1);
        tick(6);
        chk("table_stalls", stalls, 0);

        // sustained one transaction per cycle
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            v = '{1'b0, i[0] ? 32'h2000_0FFC : 32'h2000_0020, 4'hF, 32'h0, i[0],
                  i[0] ? 32'h0BAD_F00D : 32'hCAFE_0020, 1'b0};
            issue(v, 1'b1);
        end
        tick(6);
        chk("sustain_stalls", stalls, 0);
        chk("sustain_drained", sb.size(), 0);

        // backpressure: four accepts fill the outstanding window
        rready = 0;
        issue('{1'b0, 32'h2000_0010, 4'hF, 32'h0, 1'b0, 32'hDE22_BE44, 1'b0}, 1'b0);
        issue('{1'b0, 32'h2000_0000, 4'hF, 32'h0, 1'b1, 32'hA5A5_0001, 1'b0}, 1'b0);
        issue('{1'b0, 32'h2000_0FFC, 4'hF, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b0}, 1'b0);
        issue('{1'b0, 32'h2000_0020, 4'hF, 32'h0, 1'b1, 32'hCAFE_0020, 1'b0}, 1'b0);
        req = 1; we = 0; addr = 32'h2000_0010; aid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_gnt", gnt, 0);
            chk("bp_busy", busy, 1);
            chk("bp_rvalid", rvalid, 1);
            chk("bp_rdata", rdata, 32'hDE22_BE44);
            chk("bp_rid", rid, 0);
        end
        @(posedge clk);
        #1;
        req = 0;
        rready = 1;
        @(negedge clk);
        chk("gnt_at_retire", gnt, 0);
        @(negedge clk);
        chk("gnt_after_retire", gnt, 1);
        tick(6);
        chk("bp_drained", sb.size(), 0);
        chk("bp_idle_busy", busy, 0);

        // reset with three transactions outstanding
        rready = 0;
        for (int i = 0; i < 3; i++)
            issue('{1'b0, 32'h2000_0020, 4'hF, 32'h0, i[0], 32'hCAFE_0020, 1'b0}, 1'b0);
        rst = 1;
        @(negedge clk);
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_gnt", gnt, 0);
        chk("midrst_busy", busy, 0);
        sb.delete();
        tick(2);
        rst = 0;
        rready = 1;
        @(negedge clk);
        chk("postrst_gnt", gnt, 1);
        chk("postrst_busy", busy, 0);
        chk("postrst_rvalid", rvalid, 0);
        tick(10);
        issue('{1'b0, 32'h2000_0020, 4'hF, 32'h0, 1'b1, 32'hCAFE_0020, 1'b0}, 1'b1);
        tick(6);
        chk("final_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/obi_sbr_mem_responder.md
Name: obi_sbr_mem_responder

Overview:
- OBI subordinate (responder) terminating core data-port OBI requests: ADDR_W=32 / DATA_W=32, 1-bit rid, optional rready.
- Backed by an internal word-addressed memory.
- Acts as the tile-side L2 model at 0x2000_0000 and as the target end of the core OBI crossbar's L2 rule.
- Fixed access latency, bounded outstanding transactions, in-order responses with backpressure, error response for out-of-range addresses.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; STRB_W = DATA_W/8.
- ID_W, 1, aid/rid width.
- BASE_ADDR, 32'h2000_0000, first byte address served.
- N_WORDS, 1024, memory depth in DATA_W words.
- LATENCY, 2, cycles from accept to earliest rvalid; legal range 1..8.
- MAX_OUTSTANDING, 4, accepted-but-unretired transaction limit; ≥1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_i  in  1  OBI request valid.
- gnt_o  out  1  OBI grant.
- addr_i  in  ADDR_W  byte address.
- we_i  in  1  1 = write.
- be_i  in  STRB_W  byte enables.
- wdata_i  in  DATA_W  write data.
- aid_i  in  ID_W  request ID.
- rvalid_o  out  1  response valid.
- rready_i  in  1  manager ready for response; tie to 1 for managers without rready.
- rdata_o  out  DATA_W  read data.
- rid_o  out  ID_W  response ID (= aid of the matching request).
- err_o  out  1  error response.
- busy_o  out  1  outstanding count != 0.

Behaviour:
- Reset values: gnt_o=0 while rst_i is high; rvalid_o=0, rdata_o=0, rid_o=0, err_o=0, busy_o=0.
- Memory contents are not reset.
- Reset asserted mid-operation discards all in-flight and queued responses and zeroes the outstanding counter.
- Accept: a transaction is accepted when req_i && gnt_o.
- Grant: gnt_o = (cnt < MAX_OUTSTANDING), combinational from registered cnt. gnt_o may be high with req_i low. No dependency on req_i, which avoids combinational loops.
- Counter: cnt increments on accept and decrements on retire (rvalid_o && rready_i). Both in the same cycle leaves cnt unchanged. cnt never exceeds MAX_OUTSTANDING and never underflows.
- Decode: off = addr_i - BASE_ADDR; in range iff addr_i ≥ BASE_ADDR and off[ADDR_W-1:2] < N_WORDS. Index = off>>2; addr_i[1:0] is ignored.
- In-range write: mem[idx] byte k <= wdata_i byte k for each be_i[k]=1, committed at the accept clock edge. Response has rdata=0, err=0.
- In-range read: data sampled from mem[idx] at the accept edge. A write accepted in cycle t is visible to a read accepted in cycle t+1. Response has err=0.
- Out-of-range access: memory untouched; response has rdata=0, err=1.
- be_i=0 write: no bytes change; normal response.
- Pipeline: LATENCY-stage shift register carrying {valid, rid, rdata, err} into a response FIFO of depth MAX_OUTSTANDING (first-word-fall-through). The output registers present the FIFO head.
- Earliest timing: accept at cycle t gives rvalid_o at cycle t+LATENCY when the FIFO is empty and no older response is pending.
- Ordering: responses are strictly in acceptance order.
- Backpressure: while rvalid_o && !rready_i, rvalid_o, rdata_o, rid_o and err_o hold stable (OBI stability rule). Later responses queue in the FIFO. The cnt bound guarantees the FIFO never overflows, so the pipeline never stalls.
- Throughput: one accept per cycle sustained when rready_i=1 and MAX_OUTSTANDING ≥ LATENCY+1. Otherwise gnt_o drops at cnt==MAX_OUTSTANDING and re-asserts the cycle after a retire.
- Retire at full: a retire in the cycle cnt==MAX_OUTSTANDING re-opens gnt_o in the next cycle, not in the same cycle.
- busy_o is registered-equivalent: cnt != 0.

Test Plan:
1. Reset, then write 0xDEAD_BEEF at 0x2000_0010 with be=4'hF, aid=1, then read it with aid=0 and rready=1 → write response at t+2 with err=0, rid=1; read response rdata=0xDEAD_BEEF, rid=0, rvalid exactly 2 cycles after its accept.
2. Partial write, be=4'b0101, wdata=0x1122_3344 over 0xDEAD_BEEF, then read → 0xDE22_BE44.
3. Out of range: read 0x1FFF_FFFC and write 0x2000_1000 (N_WORDS=1024) → both err=1, rdata=0; a following read of 0x2000_0000 shows the previous contents unchanged.
4. Backpressure: rready=0 with req held high → exactly 4 grants, then gnt=0 and busy=1; rvalid held with stable rdata/rid. Raise rready → 4 responses in order with IDs 0,1,0,1; gnt re-asserts the cycle after the first retire.
5. Back-to-back write then read at 0x2000_0020 in consecutive cycles with rready=1 → read returns the new data; sustained 1 transaction/cycle for 16 cycles with no gnt drop.
6. Assert rst_i with 3 outstanding transactions → rvalid=0, gnt=0 during reset; after release gnt=1, busy=0, and no stale responses appear.
